// File: rtl/recorder_ctrl.sv
// Audio record/playback controller: buttons drive IDLE/REC/PLAY, samples stream to/from SRAM slots.
// Optional: define RECORDER_LOOP_EN to make playback wrap to the slot start until a stop edge.
module recorder_ctrl #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16,
  parameter int SLOT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_play,
  input  logic              btn_record,
  input  logic              btn_stop,
  input  logic [SLOT_W-1:0] slot_sel,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              dac_req,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        state,
  output logic              slot_full,
  output logic              overrun
);

  localparam int OFF_W     = ADDR_W - SLOT_W;
  localparam int PTR_W     = OFF_W + 1;
  localparam int NUM_SLOTS = 2 ** SLOT_W;
  localparam logic [PTR_W-1:0] SLOT_LEN = {1'b1, {OFF_W{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  state_t             st_q;
  logic [SLOT_W-1:0]  slot_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   len_q [NUM_SLOTS];
  logic               stop_pend_q;
  logic               play_d_q, rec_d_q, stop_d_q;

  logic               play_rise, rec_rise, stop_rise;
  logic [PTR_W-1:0]   ptr_inc;

  assign play_rise = btn_play & ~play_d_q;
  assign rec_rise  = btn_record & ~rec_d_q;
  assign stop_rise = btn_stop & ~stop_d_q;
  assign ptr_inc   = ptr_q + PTR_W'(1);
  assign state     = st_q;

  // NOTE: all state updates below use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q        <= ST_IDLE;
      slot_q      <= '0;
      ptr_q       <= '0;
      stop_pend_q <= 1'b0;
      play_d_q    <= 1'b0;
      rec_d_q     <= 1'b0;
      stop_d_q    <= 1'b0;
      dac_data    <= '0;
      dac_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      slot_full   <= 1'b0;
      overrun     <= 1'b0;
      // NOTE: the length table is a small register file that playback consults
      // directly, so it must be cleared by reset rather than left undefined.
      for (int i = 0; i < NUM_SLOTS; i++) len_q[i] <= '0;
    end else begin
      play_d_q  <= btn_play;
      rec_d_q   <= btn_record;
      stop_d_q  <= btn_stop;
      dac_valid <= 1'b0;

      case (st_q)
        ST_IDLE: begin
          if (dac_req) begin
            dac_valid <= 1'b1;
            dac_data  <= '0;
          end
          // A stop edge in IDLE has nothing to stop but still outranks record/play.
          if (!stop_rise) begin
            if (rec_rise) begin
              st_q            <= ST_REC;
              slot_q          <= slot_sel;
              ptr_q           <= '0;
              len_q[slot_sel] <= '0;
              slot_full       <= 1'b0;
            end else if (play_rise && len_q[slot_sel] != '0) begin
              st_q   <= ST_PLAY;
              slot_q <= slot_sel;
              ptr_q  <= '0;
            end
          end
        end

        ST_REC: begin
          if (mem_we) begin
            if (adc_valid) overrun <= 1'b1;
            if (mem_ack) begin
              mem_we        <= 1'b0;
              ptr_q         <= ptr_inc;
              len_q[slot_q] <= ptr_inc;
              stop_pend_q   <= 1'b0;
              if (ptr_inc == SLOT_LEN) begin
                st_q      <= ST_IDLE;
                slot_full <= 1'b1;
              end else if (stop_pend_q || stop_rise) begin
                st_q <= ST_IDLE;
              end
            end else if (stop_rise) begin
              stop_pend_q <= 1'b1;
            end
          end else if (stop_rise) begin
            st_q <= ST_IDLE;
          end else if (adc_valid) begin
            mem_we    <= 1'b1;
            mem_addr  <= {slot_q, ptr_q[OFF_W-1:0]};
            mem_wdata <= adc_data;
          end
        end

        ST_PLAY: begin
          if (mem_re) begin
            if (dac_req) overrun <= 1'b1;
            if (mem_ack) begin
              mem_re      <= 1'b0;
              dac_data    <= mem_rdata;
              dac_valid   <= 1'b1;
              ptr_q       <= ptr_inc;
              stop_pend_q <= 1'b0;
              if (stop_pend_q || stop_rise) begin
                st_q <= ST_IDLE;
              end else if (ptr_inc == len_q[slot_q]) begin
`ifdef RECORDER_LOOP_EN
                ptr_q <= '0;
`else
                st_q <= ST_IDLE;
`endif
              end
            end else if (stop_rise) begin
              stop_pend_q <= 1'b1;
            end
          end else if (stop_rise) begin
            st_q <= ST_IDLE;
          end else if (dac_req) begin
            mem_re   <= 1'b1;
            mem_addr <= {slot_q, ptr_q[OFF_W-1:0]};
          end
        end

        default: st_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recorder_ctrl.sv
// Self-checking bench for recorder_ctrl: directed scenarios with random data and ack delays,
// checked against a per-slot sample-queue model.
module tb_recorder_ctrl;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int SLOT_WORDS = 1 << (AW - 2);
`ifdef RECORDER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          btn_play = 1'b0, btn_record = 1'b0, btn_stop = 1'b0;
  logic [1:0]    slot_sel = '0;
  logic          adc_valid = 1'b0;
  logic [DW-1:0] adc_data = '0;
  logic          dac_req = 1'b0;
  logic [DW-1:0] dac_data;
  logic          dac_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic [1:0]    state;
  logic          slot_full, overrun;

  // Small instance (ADDR_W=4) exercising the slot-full boundary.
  logic          s_btn_record = 1'b0;
  logic          s_adc_valid = 1'b0;
  logic [DW-1:0] s_adc_data = '0;
  logic [DW-1:0] s_dac_data;
  logic          s_dac_valid;
  logic [3:0]    s_mem_addr;
  logic [DW-1:0] s_mem_wdata;
  logic          s_mem_we, s_mem_re;
  logic          s_mem_ack = 1'b0;
  logic [1:0]    s_state;
  logic          s_slot_full, s_overrun;

  recorder_ctrl dut (
    .clk(clk), .reset(reset), .btn_play(btn_play), .btn_record(btn_record), .btn_stop(btn_stop),
    .slot_sel(slot_sel), .adc_valid(adc_valid), .adc_data(adc_data), .dac_req(dac_req),
    .dac_data(dac_data), .dac_valid(dac_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .state(state), .slot_full(slot_full), .overrun(overrun)
  );

  recorder_ctrl #(.ADDR_W(4), .DATA_W(DW), .SLOT_W(2)) dut_s (
    .clk(clk), .reset(reset), .btn_play(1'b0), .btn_record(s_btn_record), .btn_stop(1'b0),
    .slot_sel(2'd0), .adc_valid(s_adc_valid), .adc_data(s_adc_data), .dac_req(1'b0),
    .dac_data(s_dac_data), .dac_valid(s_dac_valid), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_we(s_mem_we), .mem_re(s_mem_re), .mem_rdata('0), .mem_ack(s_mem_ack),
    .state(s_state), .slot_full(s_slot_full), .overrun(s_overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // SRAM model: acks after ack_delay cycles of an asserted request, commits writes on ack.
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  int ack_delay = 1;
  int ack_cnt = 0;

  always @(negedge clk) begin
    if (reset || mem_ack) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_we || mem_re) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          wr_addr_q.push_back(mem_addr);
          wr_data_q.push_back(mem_wdata);
        end else begin
          mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : '0;
        end
      end
    end
  end

  logic [3:0] s_wr_addr_q [$];
  always @(negedge clk) begin
    if (reset || s_mem_ack) s_mem_ack = 1'b0;
    else if (s_mem_we) begin
      s_mem_ack = 1'b1;
      s_wr_addr_q.push_back(s_mem_addr);
    end
  end

  // Reference model: samples recorded per slot, in order.
  logic [DW-1:0] rec_model [4][$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int which);
    case (which)
      0: btn_play = 1'b1;
      1: btn_record = 1'b1;
      default: btn_stop = 1'b1;
    endcase
    tick();
    btn_play = 1'b0;
    btn_record = 1'b0;
    btn_stop = 1'b0;
  endtask

  task automatic wait_mem();
    for (int k = 0; k < 32; k++) begin
      if (!(mem_we || mem_re)) break;
      tick();
    end
    check("mem_req_done", {31'b0, mem_we | mem_re}, 32'd0);
  endtask

  task automatic send_sample(input logic [DW-1:0] d);
    adc_valid = 1'b1;
    adc_data = d;
    tick();
    adc_valid = 1'b0;
    wait_mem();
  endtask

  task automatic play_req(output logic [DW-1:0] d);
    bit got = 1'b0;
    d = '0;
    dac_req = 1'b1;
    tick();
    dac_req = 1'b0;
    for (int k = 0; k < 32; k++) begin
      if (dac_valid) begin
        d = dac_data;
        got = 1'b1;
        break;
      end
      tick();
    end
    check("dac_valid_seen", {31'b0, got}, 32'd1);
    tick();
    check("dac_valid_one_cycle", {31'b0, dac_valid}, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int s = 0; s < 4; s++) rec_model[s].delete();
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] d;
    logic [DW-1:0] exp_d;
    int base, n;

    // Reset state
    do_reset();
    check("rst_state", {30'b0, state}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_re", {31'b0, mem_re}, 32'd0);
    check("rst_dac_valid", {31'b0, dac_valid}, 32'd0);
    check("rst_dac_data", {16'b0, dac_data}, 32'd0);
    check("rst_slot_full", {31'b0, slot_full}, 32'd0);
    check("rst_overrun", {31'b0, overrun}, 32'd0);

    // Record 1..5 into slot 1, ack after 2 cycles
    slot_sel = 2'd1;
    press(1);
    check("rec_entry_state", {30'b0, state}, 32'd1);
    ack_delay = 2;
    base = wr_addr_q.size();
    for (int i = 1; i <= 5; i++) begin
      send_sample(DW'(i));
      rec_model[1].push_back(DW'(i));
    end
    check("rec5_write_count", wr_addr_q.size() - base, 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("rec5_addr", {14'b0, wr_addr_q[base+i]}, 32'(SLOT_WORDS * 1 + i));
      check("rec5_data", {16'b0, wr_data_q[base+i]}, {16'b0, rec_model[1][i]});
    end
    press(2);
    check("rec_stop_state", {30'b0, state}, 32'd0);

    // Play slot 1: six requests; slot_sel changed mid-play must be ignored
    press(0);
    check("play_entry_state", {30'b0, state}, 32'd2);
    slot_sel = 2'd0;
    ack_delay = 1;
    for (int i = 0; i < 6; i++) begin
      play_req(d);
      if (i < rec_model[1].size()) exp_d = rec_model[1][i];
      else exp_d = LOOP ? rec_model[1][0] : '0;
      check("play_data", {16'b0, d}, {16'b0, exp_d});
    end
    check("play_end_state", {30'b0, state}, LOOP ? 32'd2 : 32'd0);
    press(2);
    check("play_stop_state", {30'b0, state}, 32'd0);

    // Random record into slot 3; last sample in flight when stop arrives
    n = $urandom_range(2, 6);
    slot_sel = 2'd3;
    press(1);
    slot_sel = 2'($urandom_range(0, 2));
    base = wr_addr_q.size();
    for (int i = 0; i < n - 1; i++) begin
      ack_delay = $urandom_range(1, 3);
      d = DW'($urandom);
      rec_model[3].push_back(d);
      send_sample(d);
    end
    ack_delay = 3;
    d = DW'($urandom);
    rec_model[3].push_back(d);
    adc_valid = 1'b1;
    adc_data = d;
    tick();
    adc_valid = 1'b0;
    press(2);
    check("stop_pending_state", {30'b0, state}, 32'd1);
    check("stop_pending_we", {31'b0, mem_we}, 32'd1);
    wait_mem();
    check("stop_done_state", {30'b0, state}, 32'd0);
    check("rand_write_count", wr_addr_q.size() - base, 32'(n));
    for (int i = 0; i < n; i++) begin
      check("rand_addr", {14'b0, wr_addr_q[base+i]}, 32'(SLOT_WORDS * 3 + i));
      check("rand_data", {16'b0, wr_data_q[base+i]}, {16'b0, rec_model[3][i]});
    end

    slot_sel = 2'd3;
    press(0);
    check("rand_play_state", {30'b0, state}, 32'd2);
    for (int i = 0; i <= n; i++) begin
      ack_delay = $urandom_range(1, 3);
      play_req(d);
      if (i < n) exp_d = rec_model[3][i];
      else exp_d = LOOP ? rec_model[3][0] : '0;
      check("rand_play_data", {16'b0, d}, {16'b0, exp_d});
    end
    press(2);
    check("rand_play_stop", {30'b0, state}, 32'd0);
    check("no_overrun_yet", {31'b0, overrun}, 32'd0);

    // Slot 1 contents must survive the slot 3 recording
    slot_sel = 2'd1;
    press(0);
    play_req(d);
    check("slot1_retained", {16'b0, d}, {16'b0, rec_model[1][0]});
    press(2);

    // Overrun: second adc_valid while a write waits on a slow ack
    do_reset();
    slot_sel = 2'd2;
    press(1);
    ack_delay = 4;
    base = wr_addr_q.size();
    adc_valid = 1'b1;
    adc_data = 16'hA5A5;
    tick();
    adc_data = 16'h5A5A;
    tick();
    adc_valid = 1'b0;
    wait_mem();
    check("ovr_write_count", wr_addr_q.size() - base, 32'd1);
    check("ovr_write_data", {16'b0, wr_data_q[base]}, 32'hA5A5);
    check("ovr_flag", {31'b0, overrun}, 32'd1);
    press(2);

    // Simultaneous record+stop from IDLE; play of an empty slot
    do_reset();
    btn_record = 1'b1;
    btn_stop = 1'b1;
    tick();
    btn_record = 1'b0;
    btn_stop = 1'b0;
    check("rec_stop_same_cycle", {30'b0, state}, 32'd0);
    slot_sel = 2'd3;
    press(0);
    check("play_empty_slot", {30'b0, state}, 32'd0);

    // Reset during an outstanding write
    slot_sel = 2'd1;
    press(1);
    ack_delay = 5;
    base = wr_addr_q.size();
    adc_valid = 1'b1;
    adc_data = 16'h1234;
    tick();
    adc_valid = 1'b0;
    check("midwrite_we", {31'b0, mem_we}, 32'd1);
    reset = 1'b1;
    tick();
    check("reset_aborts_we", {31'b0, mem_we}, 32'd0);
    check("reset_state", {30'b0, state}, 32'd0);
    reset = 1'b0;
    tick();
    press(0);
    check("play_after_reset", {30'b0, state}, 32'd0);
    check("aborted_write_not_done", wr_addr_q.size() - base, 32'd0);

    // Slot-full boundary on the 4-word-slot instance
    s_btn_record = 1'b1;
    tick();
    s_btn_record = 1'b0;
    check("s_rec_state", {30'b0, s_state}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      s_adc_valid = 1'b1;
      s_adc_data = DW'(i + 16'h100);
      tick();
      s_adc_valid = 1'b0;
      repeat (3) tick();
    end
    check("s_write_count", s_wr_addr_q.size(), 32'd4);
    for (int i = 0; i < s_wr_addr_q.size(); i++)
      check("s_write_addr", {28'b0, s_wr_addr_q[i]}, 32'(i));
    check("s_state_idle", {30'b0, s_state}, 32'd0);
    check("s_slot_full", {31'b0, s_slot_full}, 32'd1);
    check("s_no_overrun", {31'b0, s_overrun}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
